// File: rtl/conv32bto2b_stream_sched.sv
// ============================================================================
// conv32bto2b_stream_sched : packet gate, truncator and CtrlPort registers
// Rev 1.0
// ============================================================================
`default_nettype none

module conv32bto2b_stream_sched #(
  parameter int          CHDR_W    = 64,
  parameter logic [19:0] BASE_ADDR = 20'h0,
  parameter int          MAX_W     = 16
) (
  input  logic              axis_data_clk,
  input  logic              axis_data_rst_n,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [CHDR_W-1:0] s_ctx_tdata,
  input  logic [3:0]        s_ctx_tuser,
  input  logic              s_ctx_tlast,
  input  logic              s_ctx_tvalid,
  output logic              s_ctx_tready,
  output logic [CHDR_W-1:0] m_ctx_tdata,
  output logic [3:0]        m_ctx_tuser,
  output logic              m_ctx_tlast,
  output logic              m_ctx_tvalid,
  input  logic              m_ctx_tready,
  input  logic [31:0]       s_pyld_tdata,
  input  logic              s_pyld_tlast,
  input  logic              s_pyld_tvalid,
  output logic              s_pyld_tready,
  output logic [31:0]       m_pyld_tdata,
  output logic              m_pyld_tlast,
  output logic              m_pyld_tvalid,
  input  logic              m_pyld_tready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CTX   = 3'd1,
    ST_PYLD  = 3'd2,
    ST_TRUNC = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  state_t           state;
  logic             enable;
  logic             drop_mode;
  logic [MAX_W-1:0] max_words;
  logic [MAX_W-1:0] max_lat;
  logic [MAX_W-1:0] word_cnt;
  logic [31:0]      pkt_cnt;
  logic [31:0]      drop_cnt;
  logic             trunc_err;
  logic             drop_ctx_done;
  logic             drop_pyld_done;

  logic ctx_pass, pyld_pass, force_last;
  logic ctx_hs, pyld_hs, pkt_done, trunc_set, ctx_fin, pyld_fin, drop_done;

  assign ctx_pass   = (state == ST_CTX);
  assign pyld_pass  = (state == ST_PYLD);
  // Length limit is the value latched when the packet was admitted.
  assign force_last = pyld_pass && (max_lat != '0) && (word_cnt == max_lat - MAX_W'(1));

  assign s_ctx_tready  = (ctx_pass & m_ctx_tready) | ((state == ST_DROP) & ~drop_ctx_done);
  assign s_pyld_tready = (pyld_pass & m_pyld_tready) | (state == ST_TRUNC) |
                         ((state == ST_DROP) & ~drop_pyld_done);

  assign m_ctx_tvalid  = ctx_pass & s_ctx_tvalid;
  assign m_ctx_tdata   = ctx_pass ? s_ctx_tdata : '0;
  assign m_ctx_tuser   = ctx_pass ? s_ctx_tuser : '0;
  assign m_ctx_tlast   = ctx_pass & s_ctx_tlast;
  assign m_pyld_tvalid = pyld_pass & s_pyld_tvalid;
  assign m_pyld_tdata  = pyld_pass ? s_pyld_tdata : '0;
  assign m_pyld_tlast  = pyld_pass & (s_pyld_tlast | force_last);

  assign ctx_hs    = s_ctx_tvalid & s_ctx_tready;
  assign pyld_hs   = s_pyld_tvalid & s_pyld_tready;
  assign pkt_done  = pyld_pass & pyld_hs & (s_pyld_tlast | force_last);
  assign trunc_set = pyld_pass & pyld_hs & force_last & ~s_pyld_tlast;
  assign ctx_fin   = drop_ctx_done | (ctx_hs & s_ctx_tlast);
  assign pyld_fin  = drop_pyld_done | (pyld_hs & s_pyld_tlast);
  assign drop_done = (state == ST_DROP) & ctx_fin & pyld_fin;

  // Register decode
  logic [19:0] off;
  logic        wr_ctrl, wr_max, wr_status, cnt_clr;
  logic [31:0] rd_mux;
  logic        unused_data;

  assign off         = s_ctrlport_req_addr - BASE_ADDR;
  assign wr_ctrl     = s_ctrlport_req_wr && (off == 20'h00);
  assign wr_max      = s_ctrlport_req_wr && (off == 20'h04);
  assign wr_status   = s_ctrlport_req_wr && (off == 20'h10);
  assign cnt_clr     = wr_ctrl && s_ctrlport_req_data[2];
  assign unused_data = &{1'b0, s_ctrlport_req_data};

  always_comb begin
    rd_mux = '0;
    case (off)
      20'h00:  rd_mux = {30'd0, drop_mode, enable};
      20'h04:  rd_mux = 32'(max_words);
      20'h08:  rd_mux = pkt_cnt;
      20'h0C:  rd_mux = drop_cnt;
      20'h10:  rd_mux = {28'd0, state, trunc_err};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
    if (!axis_data_rst_n) begin
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
      enable               <= 1'b0;
      drop_mode            <= 1'b0;
      max_words            <= '0;
      pkt_cnt              <= '0;
      drop_cnt             <= '0;
      trunc_err            <= 1'b0;
    end else begin
      s_ctrlport_resp_ack  <= s_ctrlport_req_wr | s_ctrlport_req_rd;
      s_ctrlport_resp_data <= (s_ctrlport_req_rd && !s_ctrlport_req_wr) ? rd_mux : '0;
      if (wr_ctrl) begin
        enable    <= s_ctrlport_req_data[0];
        drop_mode <= s_ctrlport_req_data[1];
      end
      if (wr_max) max_words <= s_ctrlport_req_data[MAX_W-1:0];
      if (cnt_clr)       pkt_cnt <= '0;
      else if (pkt_done) pkt_cnt <= pkt_cnt + 32'd1;
      if (cnt_clr)        drop_cnt <= '0;
      else if (drop_done) drop_cnt <= drop_cnt + 32'd1;
      if (trunc_set)                             trunc_err <= 1'b1;
      else if (wr_status && s_ctrlport_req_data[0]) trunc_err <= 1'b0;
    end
  end

  always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
    if (!axis_data_rst_n) begin
      state          <= ST_IDLE;
      max_lat        <= '0;
      word_cnt       <= '0;
      drop_ctx_done  <= 1'b0;
      drop_pyld_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          drop_ctx_done  <= 1'b0;
          drop_pyld_done <= 1'b0;
          if (s_ctx_tvalid && enable) begin
            state   <= ST_CTX;
            max_lat <= max_words;
          end else if (s_ctx_tvalid && drop_mode) begin
            state <= ST_DROP;
          end
        end
        ST_CTX: begin
          if (ctx_hs && s_ctx_tlast) begin
            state    <= ST_PYLD;
            word_cnt <= '0;
          end
        end
        ST_PYLD: begin
          if (pyld_hs) begin
            word_cnt <= word_cnt + MAX_W'(1);
            if (s_pyld_tlast)    state <= ST_IDLE;
            else if (force_last) state <= ST_TRUNC;
          end
        end
        ST_TRUNC: begin
          if (pyld_hs && s_pyld_tlast) state <= ST_IDLE;
        end
        ST_DROP: begin
          // Each stream stops being accepted once its own tlast has gone by.
          if (ctx_hs && s_ctx_tlast)   drop_ctx_done  <= 1'b1;
          if (pyld_hs && s_pyld_tlast) drop_pyld_done <= 1'b1;
          if (drop_done)               state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
